// File: rtl/tuner_sweep_ctrl.sv
// tuner_sweep_ctrl
//   Sweeps a ring-resonator tuning DAC from a start code to an end code in
//   fixed steps. At each point it waits for the ring to settle thermally,
//   requests a power reading, and tracks the code with the highest (drop
//   port) or lowest (thru port) detected power. On completion the tuning
//   DAC is parked on the best code found.
//
// Parameters
//   DAC_WIDTH     width of the tuning DAC code
//   ADC_WIDTH     width of the detected power word
//   SETTLE_CYCLES settle wait per point (0 allowed, gives one SETTLE cycle)
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_sweep_start           one-cycle sweep request (honoured in IDLE only)
//   i_abort                 terminate sweep
//   i_find_min              1 = search minimum, 0 = search maximum
//   i_dac_start/end/step    sweep range and increment
//   o_dac_tune              registered code to the tuning DAC
//   o_pwr_read_val/i_pwr_read_rdy                   read-request handshake
//   i_pwr_detect_val/o_pwr_detect_rdy/i_pwr_detected result handshake
//   o_busy, o_done, o_err   status (o_done, o_err are one-cycle pulses)
//   o_best_code, o_best_pwr result of the last completed sweep
module tuner_sweep_ctrl #(
  parameter int unsigned DAC_WIDTH     = 8,
  parameter int unsigned ADC_WIDTH     = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sweep_start,
  input  logic                 i_abort,
  input  logic                 i_find_min,
  input  logic [DAC_WIDTH-1:0] i_dac_start,
  input  logic [DAC_WIDTH-1:0] i_dac_end,
  input  logic [DAC_WIDTH-1:0] i_dac_step,
  output logic [DAC_WIDTH-1:0] o_dac_tune,
  output logic                 o_pwr_read_val,
  input  logic                 i_pwr_read_rdy,
  input  logic                 i_pwr_detect_val,
  output logic                 o_pwr_detect_rdy,
  input  logic [ADC_WIDTH-1:0] i_pwr_detected,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [DAC_WIDTH-1:0] o_best_code,
  output logic [ADC_WIDTH-1:0] o_best_pwr
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_REQ,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [DAC_WIDTH-1:0] code, code_nxt;
  logic [DAC_WIDTH-1:0] cfg_end, cfg_end_nxt;
  logic [DAC_WIDTH-1:0] cfg_step, cfg_step_nxt;
  logic                 find_min, find_min_nxt;
  logic [CNT_W-1:0]     settle_cnt, settle_cnt_nxt;
  logic [DAC_WIDTH-1:0] best_code, best_code_nxt;
  logic [ADC_WIDTH-1:0] best_pwr, best_pwr_nxt;
  logic [ADC_WIDTH-1:0] sample, sample_nxt;
  logic                 abort_pend, abort_pend_nxt;

  logic [DAC_WIDTH-1:0] dac_tune_nxt;
  logic [DAC_WIDTH-1:0] out_code_nxt;
  logic [ADC_WIDTH-1:0] out_pwr_nxt;
  logic                 busy_nxt, done_nxt, err_nxt, read_val_nxt, detect_rdy_nxt;

  logic [DAC_WIDTH:0]   next_sum;
  logic                 better;
  logic [DAC_WIDTH-1:0] upd_code;
  logic [ADC_WIDTH-1:0] upd_pwr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_IDLE;
      code             <= '0;
      cfg_end          <= '0;
      cfg_step         <= '0;
      find_min         <= 1'b0;
      settle_cnt       <= '0;
      best_code        <= '0;
      best_pwr         <= '0;
      sample           <= '0;
      abort_pend       <= 1'b0;
      o_dac_tune       <= '0;
      o_best_code      <= '0;
      o_best_pwr       <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_err            <= 1'b0;
      o_pwr_read_val   <= 1'b0;
      o_pwr_detect_rdy <= 1'b0;
    end else begin
      state            <= state_nxt;
      code             <= code_nxt;
      cfg_end          <= cfg_end_nxt;
      cfg_step         <= cfg_step_nxt;
      find_min         <= find_min_nxt;
      settle_cnt       <= settle_cnt_nxt;
      best_code        <= best_code_nxt;
      best_pwr         <= best_pwr_nxt;
      sample           <= sample_nxt;
      abort_pend       <= abort_pend_nxt;
      o_dac_tune       <= dac_tune_nxt;
      o_best_code      <= out_code_nxt;
      o_best_pwr       <= out_pwr_nxt;
      o_busy           <= busy_nxt;
      o_done           <= done_nxt;
      o_err            <= err_nxt;
      o_pwr_read_val   <= read_val_nxt;
      o_pwr_detect_rdy <= detect_rdy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    code_nxt       = code;
    cfg_end_nxt    = cfg_end;
    cfg_step_nxt   = cfg_step;
    find_min_nxt   = find_min;
    settle_cnt_nxt = settle_cnt;
    best_code_nxt  = best_code;
    best_pwr_nxt   = best_pwr;
    sample_nxt     = sample;
    abort_pend_nxt = abort_pend;
    dac_tune_nxt   = o_dac_tune;
    out_code_nxt   = o_best_code;
    out_pwr_nxt    = o_best_pwr;
    err_nxt        = 1'b0;

    // One extra bit so code + step past the top of the DAC range is seen
    // as "beyond end" instead of wrapping to a low code.
    next_sum = {1'b0, code} + {1'b0, cfg_step};
    better   = find_min ? (sample < best_pwr) : (sample > best_pwr);
    upd_code = better ? code   : best_code;
    upd_pwr  = better ? sample : best_pwr;

    case (state)
      S_IDLE: begin
        abort_pend_nxt = 1'b0;
        if (i_sweep_start) begin
          if ((i_dac_start > i_dac_end) || (i_dac_step == '0)) begin
            err_nxt = 1'b1;
          end else begin
            code_nxt       = i_dac_start;
            dac_tune_nxt   = i_dac_start;
            cfg_end_nxt    = i_dac_end;
            cfg_step_nxt   = i_dac_step;
            find_min_nxt   = i_find_min;
            settle_cnt_nxt = SETTLE_LOAD;
            best_code_nxt  = i_dac_start;
            best_pwr_nxt   = i_find_min ? '1 : '0;
            state_nxt      = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (i_abort) begin
          state_nxt = S_IDLE;
        end else if (settle_cnt == '0) begin
          state_nxt = S_REQ;
        end else begin
          settle_cnt_nxt = settle_cnt - CNT_W'(1);
        end
      end
      S_REQ: begin
        if (i_abort) begin
          state_nxt = S_IDLE;
        end else if (i_pwr_read_rdy) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // An abort here is deferred until the detector has handed over its
        // result, so no stale reading is left queued for the next sweep.
        if (i_abort) begin
          abort_pend_nxt = 1'b1;
        end
        if (i_pwr_detect_val) begin
          sample_nxt = i_pwr_detected;
          if (abort_pend || i_abort) begin
            abort_pend_nxt = 1'b0;
            state_nxt      = S_IDLE;
          end else begin
            state_nxt = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        if (i_abort) begin
          state_nxt = S_IDLE;
        end else begin
          best_code_nxt = upd_code;
          best_pwr_nxt  = upd_pwr;
          if (next_sum > {1'b0, cfg_end}) begin
            // Result is published on entry to DONE so it is valid while
            // o_done is high.
            dac_tune_nxt = upd_code;
            out_code_nxt = upd_code;
            out_pwr_nxt  = upd_pwr;
            state_nxt    = S_DONE;
          end else begin
            code_nxt       = next_sum[DAC_WIDTH-1:0];
            dac_tune_nxt   = next_sum[DAC_WIDTH-1:0];
            settle_cnt_nxt = SETTLE_LOAD;
            state_nxt      = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the state being entered.
    busy_nxt       = (state_nxt != S_IDLE);
    done_nxt       = (state_nxt == S_DONE);
    read_val_nxt   = (state_nxt == S_REQ);
    detect_rdy_nxt = (state_nxt == S_WAIT);
  end

endmodule
